// File: rtl/mic_pair_framer_pkg.sv
// Shared widths and helpers for the microphone stereo-pair framer.
// DATAWIDTH_DEF is the default per-channel sample width used by the top level.
package mic_pair_framer_pkg;

    localparam int DATAWIDTH_DEF = 24;
    localparam int SEQ_W         = 16;
    localparam int DROP_W        = 8;

    typedef logic [SEQ_W-1:0]  seq_t;
    typedef logic [DROP_W-1:0] drop_t;

    // Drop counter holds at all-ones instead of wrapping back to zero.
    function automatic drop_t drop_sat_inc(input drop_t v);
        return (v == '1) ? v : drop_t'(v + 1'b1);
    endfunction

endpackage

// File: rtl/mic_pair_framer_fifo.sv
// First-word-fall-through synchronous FIFO holding captured stereo pairs.
// A push while full is accepted only when a pop frees the head slot in the same cycle.
import mic_pair_framer_pkg::*;

module sync_fifo_fwft #(
    parameter int WIDTH = 2 * DATAWIDTH_DEF + SEQ_W,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage is not reset; the head is masked to zero while empty instead.
    assign head = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mic_pair_framer.sv
// Frames left/right I2S samples into sequence-numbered stereo pairs on a
// valid/ready stream, counting pairs dropped when the buffer is full.
import mic_pair_framer_pkg::*;

module mic_pair_framer #(
    parameter int DATAWIDTH  = DATAWIDTH_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_mic,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic                   ws,
    input  logic [DATAWIDTH-1:0]   l_data,
    input  logic [DATAWIDTH-1:0]   r_data,
    input  logic                   recv_over,
    output logic                   m_valid,
    input  logic                   m_ready,
    output logic [2*DATAWIDTH-1:0] m_data,
    output logic [SEQ_W-1:0]       m_seq,
    output logic                   ovf,
    input  logic                   clr_ovf,
    output logic [DROP_W-1:0]      drop_cnt
);

    localparam int ENTRY_W = 2 * DATAWIDTH + SEQ_W;

    logic               recv_over_d;
    seq_t               seq_cnt;
    logic               pair_done;
    logic               capture;
    logic               pop;
    logic               overflow;
    logic               full;
    logic               empty;
    logic [ENTRY_W-1:0] head;

    // The falling edge of recv_over during the right half means both samples are final.
    assign pair_done = recv_over_d & ~recv_over & ws;
    assign capture   = pair_done & enable;
    assign m_valid   = ~empty;
    assign pop       = m_valid & m_ready;
    assign overflow  = capture & full & ~pop;

    assign m_data = head[ENTRY_W-1:SEQ_W];
    assign m_seq  = head[SEQ_W-1:0];

    sync_fifo_fwft #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk_mic),
        .rst_n     (rst_n),
        .push      (capture),
        .push_data ({l_data, r_data, seq_cnt}),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

    always_ff @(posedge clk_mic or negedge rst_n) begin
        if (!rst_n) begin
            recv_over_d <= 1'b0;
            seq_cnt     <= '0;
            ovf         <= 1'b0;
            drop_cnt    <= '0;
        end else begin
            recv_over_d <= recv_over;
            // Dropped pairs still consume a sequence number so gaps stay visible downstream.
            if (capture) begin
                seq_cnt <= seq_cnt + 1'b1;
            end
            if (overflow) begin
                ovf      <= 1'b1;
                drop_cnt <= clr_ovf ? drop_t'(1) : drop_sat_inc(drop_cnt);
            end else if (clr_ovf) begin
                ovf      <= 1'b0;
                drop_cnt <= '0;
            end
        end
    end

endmodule

// File: doc/mic_pair_framer.md
MIC_PAIR_FRAMER -- requirements
Module: mic_pair_framer

Interface
REQ-001 SHALL have parameter DATAWIDTH, default 24, sample width per channel.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of buffered stereo pairs; power of two, at least 2.
REQ-003 SHALL have port clk_mic, input, 1, the single clock (64*fs); every register updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-005 SHALL have port enable, input, 1, capture enable.
REQ-006 SHALL have port ws, input, 1, word select from the mic bus; 0 = left half, 1 = right half.
REQ-007 SHALL have port l_data, input, DATAWIDTH, left sample from the I2S decoder.
REQ-008 SHALL have port r_data, input, DATAWIDTH, right sample from the I2S decoder.
REQ-009 SHALL have port recv_over, input, 1, one-cycle "half-frame received" pulse from the decoder.
REQ-010 SHALL have port m_valid, output, 1, output pair available.
REQ-011 SHALL have port m_ready, input, 1, downstream accepts the pair.
REQ-012 SHALL have port m_data, output, 2*DATAWIDTH, packed pair {left, right}; left in the MSBs.
REQ-013 SHALL have port m_seq, output, 16, capture sequence number of the pair on m_data.
REQ-014 SHALL have port ovf, output, 1, sticky overflow flag.
REQ-015 SHALL have port clr_ovf, input, 1, clears ovf and drop_cnt.
REQ-016 SHALL have port drop_cnt, output, 8, count of dropped pairs; saturates at 255.

Function
REQ-017 SHALL register recv_over into recv_over_d each cycle.
REQ-018 SHALL raise pair_done when recv_over_d=1, recv_over=0 and ws=1.
  - pair_done marks right-half completion: l_data and r_data both hold the finished frame.
  - A left-half completion (ws=0) SHALL NOT raise pair_done.
REQ-019 SHALL push {l_data, r_data} and the current seq_cnt into the FIFO on the cycle pair_done=1 and enable=1.
REQ-020 SHALL increment seq_cnt by 1 on every pair_done with enable=1, wrapping from 0xFFFF to 0x0000, whether the push succeeds or the pair is dropped.
REQ-021 SHALL pop the FIFO on the rising edge where m_valid=1 and m_ready=1.
REQ-022 SHALL drive m_valid=1 exactly when the FIFO is non-empty (first-word-fall-through).
  - m_data and m_seq SHALL always show the head entry.
  - Latency: pair_done edge to m_valid=1 is 1 cycle.
REQ-023 SHALL hold m_data and m_seq stable while m_valid=1 and m_ready=0.
REQ-024 SHALL, on a push while full with no pop in the same cycle:
  - discard the new pair;
  - set ovf=1;
  - increment drop_cnt, saturating at 255;
  - leave FIFO contents unchanged.
REQ-025 SHALL, on a push and a pop in the same cycle while full, accept the new pair with no overflow.
REQ-026 SHALL, on a push and a pop in the same cycle while non-full and non-empty, leave occupancy unchanged.
REQ-027 SHALL, when clr_ovf=1 in the same cycle as an overflow, give priority to the overflow: ovf=1, drop_cnt=1.
REQ-028 SHALL ignore pair_done while enable=0.
  - Deasserting enable SHALL NOT flush the FIFO.
  - Pops continue normally while enable=0.
REQ-029 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH and track occupancy with a counter of width log2(FIFO_DEPTH)+1.

Reset
REQ-030 SHALL, while rst_n=0, force all of the following: m_valid=0, m_data=0, m_seq=0, ovf=0, drop_cnt=0, seq_cnt=0, recv_over_d=0, FIFO pointers=0, occupancy=0.
REQ-031 SHALL, after a reset taken mid-operation, discard all buffered pairs and start from an empty FIFO.
REQ-032 SHALL raise no spurious pair_done on the first cycle after reset release.

Structure
REQ-033 SHALL place the shared constants in the common include file: default DATAWIDTH=24, SEQ_W=16, DROP_W=8.
REQ-034 SHALL implement buffering in one sub-module, sync_fifo_fwft, parameterised by width (2*DATAWIDTH+SEQ_W) and depth, exposing full and empty.
REQ-035 SHALL keep pair detection, sequence counting and overflow logic in mic_pair_framer itself.

Verification
REQ-036 Single pair: l_data=0x123456, r_data=0xABCDEF, recv_over pulse with ws=1 -> next cycle m_valid=1, m_data=0x123456ABCDEF, m_seq=0.
REQ-037 Left-only event: recv_over pulse with ws=0 -> m_valid stays 0, seq_cnt unchanged.
REQ-038 Backpressure: m_ready=0, 5 pairs with FIFO_DEPTH=4 -> 4 stored with seq 0..3, ovf=1, drop_cnt=1; then m_ready=1 -> pops seq 0,1,2,3 in order.
REQ-039 Full plus simultaneous pop: FIFO full, m_ready=1 on the cycle of pair_done -> pair accepted, ovf stays 0, occupancy stays 4.
REQ-040 Wrap and saturation: 65537 pairs -> m_seq wraps to 0x0000 after 0xFFFF; 300 overflows -> drop_cnt=255; clr_ovf -> ovf=0, drop_cnt=0.
REQ-041 Reset mid-stream: assert rst_n=0 with 3 pairs buffered -> m_valid=0 immediately; after release the next pair has m_seq=0.
